// File: rtl/mips_run_ctrl_if.sv
// Control bus between the debug front-end and the run/halt sequencer.
// master: request side (toggle/step requests, breakpoint setup, core PC).
// slave : sequencer side (core enable, state, breakpoint flag, retired count).
interface mips_run_ctrl_if #(
   parameter int unsigned PC_W   = 8,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned STEP_W = 8
) ();
   logic              change;
   logic              step;
   logic [STEP_W-1:0] step_cnt;
   logic              bp_en;
   logic [PC_W-1:0]   bp_addr;
   logic [PC_W-1:0]   pc;
   logic              cpu_en;
   logic [1:0]        state;
   logic              bp_hit;
   logic [CNT_W-1:0]  retired;

   modport master (
      output change, step, step_cnt, bp_en, bp_addr, pc,
      input  cpu_en, state, bp_hit, retired
   );

   modport slave (
      input  change, step, step_cnt, bp_en, bp_addr, pc,
      output cpu_en, state, bp_hit, retired
   );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle mips core.
// Ports:
//   clk  - system clock, all state updates on posedge
//   rst  - asynchronous active-high reset
//   bus  - slave side of mips_run_ctrl_if:
//          in : change, step (rising edge acts), step_cnt (0 means 1),
//               bp_en, bp_addr, pc (instruction about to execute)
//          out: cpu_en (combinational), state (00 HALT/01 RUN/10 STEP/11 BRK),
//               bp_hit (1 while BRK), retired (instructions executed)
module mips_run_ctrl #(
   parameter int unsigned PC_W   = 8,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned STEP_W = 8
) (
   input logic              clk,
   input logic              rst,
   mips_run_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_BRK  = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic [STEP_W-1:0] remain_q, remain_d;
   logic              skip_q, skip_d;
   logic              bp_hit_q, bp_hit_d;
   logic              chg_q, stp_q;
   logic [CNT_W-1:0]  retired_q;

   logic              chg_rise, stp_rise, bpm, cpu_en_c;
   logic [STEP_W-1:0] load_cnt;

   // Request edge detect; rises are single-cycle and never queued.
   assign chg_rise = bus.change & ~chg_q;
   assign stp_rise = bus.step & ~stp_q;

   // skip masks the breakpoint for the first instruction after a resume from BRK.
   assign bpm      = bus.bp_en & (bus.pc == bus.bp_addr) & ~skip_q;
   assign cpu_en_c = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~bpm;
   assign load_cnt = (bus.step_cnt == '0) ? STEP_W'(1) : bus.step_cnt;

   // State and bookkeeping registers. Edge-detect flops reset high so a
   // request held through reset does not fire on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HALT;
         remain_q  <= '0;
         skip_q    <= 1'b0;
         bp_hit_q  <= 1'b0;
         chg_q     <= 1'b1;
         stp_q     <= 1'b1;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         skip_q    <= skip_d;
         bp_hit_q  <= bp_hit_d;
         chg_q     <= bus.change;
         stp_q     <= bus.step;
         if (cpu_en_c) retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Next-state logic; change has priority over step.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      skip_d   = cpu_en_c ? 1'b0 : skip_q;
      case (state_q)
         ST_HALT: begin
            if (chg_rise) begin
               state_d = ST_RUN;
               skip_d  = 1'b0;
            end else if (stp_rise) begin
               state_d  = ST_STEP;
               remain_d = load_cnt;
               skip_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (chg_rise)  state_d = ST_HALT;
            else if (bpm)  state_d = ST_BRK;
         end
         ST_STEP: begin
            if (chg_rise) begin
               state_d  = ST_HALT;
               remain_d = '0;
            end else if (bpm) begin
               state_d  = ST_BRK;
               remain_d = '0;
            end else begin
               remain_d = remain_q - STEP_W'(1);
               if (remain_q == STEP_W'(1)) state_d = ST_HALT;
            end
         end
         ST_BRK: begin
            if (chg_rise) begin
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end else if (stp_rise) begin
               state_d  = ST_STEP;
               remain_d = load_cnt;
               skip_d   = 1'b1;
            end
         end
         default: state_d = ST_HALT;
      endcase
      bp_hit_d = (state_d == ST_BRK);
   end

   assign bus.cpu_en  = cpu_en_c;
   assign bus.state   = state_q;
   assign bus.bp_hit  = bp_hit_q;
   assign bus.retired = retired_q;

endmodule
